// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-memory read at a time, returned words buffered
// in a 2-entry FIFO with their fetch address. Flush discards buffered and in-flight words.
module instruction_fetch #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 fetch_enable,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] pc,
  output logic                 pc_update_enable,
  output logic [WORD_SIZE-1:0] pc_value,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_resp_valid,
  input  logic [WORD_SIZE-1:0] mem_resp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr_data,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic [1:0]           state_dbg
);

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 active_q;
  logic                 flush_d;
  logic                 req_pending_q;
  logic [WORD_SIZE-1:0] tag_q;
  logic [WORD_SIZE-1:0] fifo_data [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] fifo_pc   [FIFO_DEPTH];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;
  logic                 have_room, issue_new, req_fire, push, pop;

  // Handshakes: a transfer happens in any cycle where valid & ready are both high. A raised
  // mem_req_valid holds with a stable mem_addr until accepted (only flush retracts it);
  // instr_valid presents the registered FIFO head, consumed by instr_ready.
  always_comb begin
    // Requests only leave IDLE, so no entry is reserved by an outstanding read here.
    have_room     = (count < 2'(FIFO_DEPTH));
    issue_new     = fetch_enable & ~flush_d & have_room;
    mem_req_valid = active_q & (state_q == IDLE) & ~flush & (req_pending_q | issue_new);
    req_fire      = mem_req_valid & mem_req_ready;
    push          = (state_q == WAIT) & mem_resp_valid & ~flush;
    pop           = instr_valid & instr_ready & ~flush;

    state_d = state_q;
    case (state_q)
      IDLE:  if (req_fire) state_d = WAIT;
      WAIT: begin
        if (flush)               state_d = mem_resp_valid ? IDLE : DRAIN;
        else if (mem_resp_valid) state_d = IDLE;
      end
      DRAIN: if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pc_update_enable = req_fire;
  assign pc_value         = WORD_SIZE'(1);
  assign mem_addr         = pc;
  assign instr_valid      = (count != 2'd0);
  assign instr_data       = fifo_data[rd_ptr];
  assign instr_pc         = fifo_pc[rd_ptr];
  assign state_dbg        = state_q;

  // active_q keeps the request port quiet while reset is held and for the release cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      active_q      <= 1'b0;
      flush_d       <= 1'b0;
      req_pending_q <= 1'b0;
      tag_q         <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= 1'b1;
      flush_d       <= flush;
      req_pending_q <= mem_req_valid & ~mem_req_ready;
      if (req_fire) tag_q <= pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_resp_data;
        fifo_pc[wr_ptr]   <= tag_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: program_counter and memory stand-ins, directed scenarios and
// a randomized run checked against an in-order expected fetch-address queue.
module tb_instruction_fetch;

  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         fetch_enable = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] pc = '0;
  logic         pc_update_enable;
  logic [W-1:0] pc_value;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [W-1:0] mem_addr;
  logic         mem_resp_valid = 1'b0;
  logic [W-1:0] mem_resp_data = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [W-1:0] instr_data;
  logic [W-1:0] instr_pc;
  logic [1:0]   state_dbg;

  instruction_fetch #(.WORD_SIZE(W)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_enable(fetch_enable), .flush(flush), .pc(pc),
    .pc_update_enable(pc_update_enable), .pc_value(pc_value),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  logic [W-1:0] mem_arr [256];
  logic [W-1:0] resp_addr_q[$];
  int           resp_due_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fire_addr_q[$];
  int           fire_cyc_q[$];
  int           fixed_lat = 1;
  bit           rand_lat = 0;
  int           n_upd = 0;
  int           n_pops = 0;
  bit           set_en = 0;
  logic [W-1:0] set_val = '0;
  bit           prev_pending = 0;
  logic [W-1:0] prev_addr = '0;
  bit           last_resp = 0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return mem_arr[a[7:0]];
  endfunction

  task automatic fill_exp(input logic [W-1:0] base);
    exp_q.delete();
    for (int k = 0; k < 1000; k++) exp_q.push_back(base + W'(k));
  endtask

  task automatic clear_models();
    resp_addr_q.delete();
    resp_due_q.delete();
    fire_addr_q.delete();
    fire_cyc_q.delete();
    n_upd = 0;
    n_pops = 0;
    prev_pending = 0;
    set_en = 0;
    cyc = 0;
    pc = '0;
    fill_exp('0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    fetch_enable = 1'b0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    instr_ready = 1'b0;
    rand_lat = 0;
    fixed_lat = 1;
    repeat (2) @(negedge clock);
    clear_models();
    reset_n = 1'b1;
  endtask

  // One clock cycle: memory responder, monitors and scoreboard, then the program_counter update.
  task automatic step();
    logic [W-1:0] next_pc;
    logic [W-1:0] tmp_a;
    logic [W-1:0] exp_pc;
    int           tmp_d;
    bit           fire;
    if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(resp_addr_q[0]);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
    end
    #1;
    last_resp = mem_resp_valid;
    if (mem_resp_valid) begin
      tmp_a = resp_addr_q.pop_front();
      tmp_d = resp_due_q.pop_front();
    end
    fire = mem_req_valid && mem_req_ready;
    n_checks++;
    if (pc_update_enable !== fire)
      $display("FAIL pc_update_vs_handshake cyc=%0d: got %0b expected %0b", cyc, pc_update_enable, fire);
    else n_pass++;
    if (fire) begin
      n_checks++;
      if (resp_addr_q.size() != 0 || mem_addr !== pc)
        $display("FAIL req_issue cyc=%0d: outstanding=%0d addr=%0h expected 0 outstanding addr=%0h",
                 cyc, resp_addr_q.size(), mem_addr, pc);
      else n_pass++;
      resp_addr_q.push_back(mem_addr);
      resp_due_q.push_back(cyc + (rand_lat ? int'($urandom_range(1, 3)) : fixed_lat));
      fire_addr_q.push_back(mem_addr);
      fire_cyc_q.push_back(cyc);
    end
    if (pc_update_enable) n_upd++;
    if (prev_pending && !flush) begin
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== prev_addr)
        $display("FAIL req_hold cyc=%0d: valid=%0b addr=%0h expected valid=1 addr=%0h",
                 cyc, mem_req_valid, mem_addr, prev_addr);
      else n_pass++;
    end
    prev_pending = mem_req_valid && !mem_req_ready;
    prev_addr    = mem_addr;
    if (instr_valid && instr_ready && !flush) begin
      n_pops++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected cyc=%0d: got pc=%0h expected no instruction", cyc, instr_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc))
          $display("FAIL pop_order cyc=%0d: got pc=%0h data=%0h expected pc=%0h data=%0h",
                   cyc, instr_pc, instr_data, exp_pc, mem_word(exp_pc));
        else n_pass++;
      end
    end
    if (set_en) next_pc = set_val;
    else if (pc_update_enable) next_pc = pc + pc_value;
    else next_pc = pc;
    if (flush) fill_exp(set_val);
    @(posedge clock);
    #1;
    pc = next_pc;
    @(negedge clock);
    cyc++;
  endtask

  task automatic test_reset();
    fetch_enable = 1'b1;
    mem_req_ready = 1'b1;
    instr_ready = 1'b0;
    #2;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0 || pc_update_enable !== 1'b0 ||
        pc_value !== W'(1) || instr_data !== '0 || instr_pc !== '0)
      $display("FAIL reset_outputs: iv=%0b rv=%0b pu=%0b pv=%0h d=%0h p=%0h expected 0,0,0,1,0,0",
               instr_valid, mem_req_valid, pc_update_enable, pc_value, instr_data, instr_pc);
    else n_pass++;
    @(negedge clock);
    clear_models();
    reset_n = 1'b1;
    for (int i = 0; i < 20 && fire_addr_q.size() < 2; i++) step();
    n_checks++;
    if (fire_addr_q.size() != 2 || fire_addr_q[0] !== '0)
      $display("FAIL reset_first_req: got %0d requests first=%0h expected 2 requests first=0",
               fire_addr_q.size(), (fire_addr_q.size() > 0) ? fire_addr_q[0] : W'(32'hdead));
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b1)
      $display("FAIL reset_precond_fifo: got instr_valid=%0b expected 1", instr_valid);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0 || pc_update_enable !== 1'b0)
      $display("FAIL reset_mid_wait: iv=%0b rv=%0b pu=%0b expected all 0",
               instr_valid, mem_req_valid, pc_update_enable);
    else n_pass++;
    @(negedge clock);
    apply_reset();
    fetch_enable = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 5 && fire_addr_q.size() < 1; i++) step();
    n_checks++;
    if (fire_addr_q.size() != 1 || fire_addr_q[0] !== '0)
      $display("FAIL reset_release_req: got %0d requests expected 1 at addr 0", fire_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_streaming();
    apply_reset();
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      fetch_enable = (n_upd < 4);
      step();
    end
    n_checks++;
    if (n_upd != 4 || n_pops != 4 || instr_valid !== 1'b0)
      $display("FAIL stream_counts: got upd=%0d pops=%0d iv=%0b expected 4 4 0", n_upd, n_pops, instr_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fire_addr_q.size() != 4 || fire_addr_q[i] !== W'(i))
        $display("FAIL stream_addr[%0d]: got %0h expected %0h", i,
                 (fire_addr_q.size() > i) ? fire_addr_q[i] : W'(32'hdead), i);
      else n_pass++;
    end
    n_checks++;
    if (fire_cyc_q.size() != 4 || fire_cyc_q[3] - fire_cyc_q[0] != 6)
      $display("FAIL stream_rate: got span %0d expected 6",
               (fire_cyc_q.size() == 4) ? fire_cyc_q[3] - fire_cyc_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_enable = 1'b1;
    mem_req_ready = 1'b1;
    instr_ready = 1'b0;
    repeat (12) step();
    n_checks++;
    if (fire_addr_q.size() != 2 || instr_valid !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL bp_full: got reqs=%0d iv=%0b rv=%0b expected 2 1 0",
               fire_addr_q.size(), instr_valid, mem_req_valid);
    else n_pass++;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    repeat (6) step();
    n_checks++;
    if (fire_addr_q.size() != 3 || fire_addr_q[fire_addr_q.size()-1] !== W'(2) || n_pops != 1)
      $display("FAIL bp_one_more: got reqs=%0d last=%0h pops=%0d expected 3 2 1", fire_addr_q.size(),
               fire_addr_q[fire_addr_q.size()-1], n_pops);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL bp_refull: got iv=%0b rv=%0b expected 1 0", instr_valid, mem_req_valid);
    else n_pass++;
  endtask

  task automatic test_flush_wait();
    int flush_cyc;
    apply_reset();
    fetch_enable = 1'b1;
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    fixed_lat = 4;
    flush = 1'b1; set_en = 1; set_val = W'(5);
    step();
    flush = 1'b0; set_en = 0;
    n_checks++;
    if (mem_req_valid !== 1'b0)
      $display("FAIL flush_block: got req_valid=%0b expected 0", mem_req_valid);
    else n_pass++;
    step();
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== W'(5))
      $display("FAIL flush_redirect_req: got valid=%0b addr=%0h expected 1 5", mem_req_valid, mem_addr);
    else n_pass++;
    step();
    step();
    flush = 1'b1; set_en = 1; set_val = W'(20);
    flush_cyc = cyc;
    step();
    flush = 1'b0; set_en = 0;
    n_checks++;
    if (instr_valid !== 1'b0)
      $display("FAIL flush_wait_empty: got instr_valid=%0b expected 0", instr_valid);
    else n_pass++;
    for (int i = 0; i < 20 && fire_addr_q.size() < 2; i++) step();
    n_checks++;
    if (fire_addr_q.size() != 2 || fire_addr_q[1] !== W'(20) || fire_cyc_q[1] - flush_cyc < 2)
      $display("FAIL flush_wait_next: got reqs=%0d addr=%0h delay=%0d expected addr 20 delay>=2",
               fire_addr_q.size(), fire_addr_q[fire_addr_q.size()-1],
               fire_cyc_q[fire_cyc_q.size()-1] - flush_cyc);
    else n_pass++;
    fetch_enable = 1'b0;
    repeat (7) step();
    n_checks++;
    if (n_pops != 1)
      $display("FAIL flush_wait_pops: got %0d expected 1", n_pops);
    else n_pass++;
  endtask

  task automatic test_flush_resp_pop();
    apply_reset();
    fetch_enable = 1'b1;
    mem_req_ready = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && fire_addr_q.size() < 2; i++) step();
    n_checks++;
    if (fire_addr_q.size() != 2 || instr_valid !== 1'b1)
      $display("FAIL frp_setup: got reqs=%0d iv=%0b expected 2 1", fire_addr_q.size(), instr_valid);
    else n_pass++;
    flush = 1'b1; set_en = 1; set_val = W'(40);
    instr_ready = 1'b1;
    step();
    flush = 1'b0; set_en = 0;
    n_checks++;
    if (last_resp !== 1'b1)
      $display("FAIL frp_coincident: got resp_valid=%0b in flush cycle expected 1", last_resp);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b0 || state_dbg !== ST_IDLE || n_pops != 0)
      $display("FAIL frp_after: got iv=%0b state=%0d pops=%0d expected 0 %0d 0",
               instr_valid, state_dbg, n_pops, ST_IDLE);
    else n_pass++;
    for (int i = 0; i < 10 && fire_addr_q.size() < 3; i++) step();
    n_checks++;
    if (fire_addr_q.size() != 3 || fire_addr_q[2] !== W'(40))
      $display("FAIL frp_next_req: got reqs=%0d expected 3rd at 40", fire_addr_q.size());
    else n_pass++;
    fetch_enable = 1'b0;
    repeat (4) step();
    n_checks++;
    if (n_pops != 1)
      $display("FAIL frp_pops: got %0d expected 1", n_pops);
    else n_pass++;
  endtask

  task automatic test_stall();
    apply_reset();
    fetch_enable = 1'b1;
    mem_req_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      fetch_enable = (i != 1);
      #1;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== '0 || pc_update_enable !== 1'b0)
        $display("FAIL stall_hold[%0d]: got rv=%0b addr=%0h pu=%0b expected 1 0 0",
                 i, mem_req_valid, mem_addr, pc_update_enable);
      else n_pass++;
      step();
    end
    fetch_enable = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if (pc_update_enable !== 1'b1 || mem_addr !== '0)
      $display("FAIL stall_accept: got pu=%0b addr=%0h expected 1 0", pc_update_enable, mem_addr);
    else n_pass++;
    step();
    n_checks++;
    if (fire_addr_q.size() != 1 || n_upd != 1)
      $display("FAIL stall_count: got reqs=%0d upd=%0d expected 1 1", fire_addr_q.size(), n_upd);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      fetch_enable  = ($urandom_range(0, 9) < 8);
      mem_req_ready = ($urandom_range(0, 9) < 7);
      instr_ready   = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 49) == 0);
      set_en        = flush;
      set_val       = W'($urandom_range(0, 200));
      step();
    end
    flush = 1'b0; set_en = 0;
    fetch_enable = 1'b0;
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (20) step();
    n_checks++;
    if (resp_addr_q.size() != 0 || instr_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL random_drain: got outstanding=%0d iv=%0b rv=%0b expected 0 0 0",
               resp_addr_q.size(), instr_valid, mem_req_valid);
    else n_pass++;
    n_checks++;
    if (n_pops <= 50)
      $display("FAIL random_progress: got %0d pops expected >50", n_pops);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_wait();
    test_flush_resp_pop();
    test_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
